vc_link_scheduler: RTL and testbench

Output-link scheduler for the router buffer stage. Shares one physical output link among NUM_VC per-virtual-channel synchronous FIFOs: picks one non-empty VC per cycle by round-robin, pops it via the FIFO's read enable, and forwards the flit one cycle later. Downstream buffer space is tracked with per-VC credit counters, so no flit is sent without a free downstream slot.

---
 rtl/noc_sched_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/vc_link_scheduler.sv | 118 +++++++++++
 tb/tb_vc_link_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_sched_pkg.sv
// Shared constants and helpers for the router output-link scheduler.
package noc_sched_pkg;

    localparam int DEF_NUM_VC   = 4;
    localparam int DEF_NUM_BITS = 32;
    localparam int DEF_CREDITS  = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int DEF_VC_W = clog2(DEF_NUM_VC);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
    import noc_sched_pkg::*;
#(
    parameter int N = DEF_NUM_VC,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            cand = W'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/vc_link_scheduler.sv
// Credit-gated round-robin scheduler sharing one output link among NUM_VC FIFOs.
// Define VC_SCHED_STATS_EN to add per-VC 16-bit grant counters on grant_cnt.
module vc_link_scheduler
    import noc_sched_pkg::*;
#(
    parameter int NUM_VC   = DEF_NUM_VC,
    parameter int NUM_BITS = DEF_NUM_BITS,
    parameter int CREDITS  = DEF_CREDITS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sched_en,
    input  logic [NUM_VC-1:0]          fifo_empty,
    input  logic [NUM_VC*NUM_BITS-1:0] fifo_data,
    output logic [NUM_VC-1:0]          fifo_rd_en,
    input  logic [NUM_VC-1:0]          credit_ret,
    output logic                       link_valid,
    output logic [clog2(NUM_VC)-1:0]   link_vc,
    output logic [NUM_BITS-1:0]        link_data,
    output logic                       cred_err
`ifdef VC_SCHED_STATS_EN
    ,
    output logic [NUM_VC*16-1:0]       grant_cnt
`endif
);

    localparam int VC_W = clog2(NUM_VC);
    localparam int CW   = clog2(CREDITS + 1);

    logic                              run_q;
    logic [VC_W-1:0]                   ptr_q;
    logic [VC_W-1:0]                   vc_q;
    logic                              vld_q;
    logic                              cred_err_q;
    logic [NUM_VC-1:0][CW-1:0]         credit_q;
    logic [NUM_VC-1:0]                 elig;
    logic [NUM_VC-1:0]                 ovf;
    logic [NUM_VC-1:0]                 gnt;
    logic [VC_W-1:0]                   gnt_idx;
    logic                              any_gnt;
    logic [NUM_VC-1:0][NUM_BITS-1:0]   fifo_vec;

    assign fifo_vec = fifo_data;

    // run_q keeps the first cycle after reset release free of pops.
    always_comb begin
        elig = '0;
        ovf  = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            elig[i] = !fifo_empty[i] && (credit_q[i] != '0) && sched_en && run_q;
            ovf[i]  = credit_ret[i] && !gnt[i] && (credit_q[i] == CW'(CREDITS));
        end
    end

    rr_arbiter #(.N(NUM_VC), .W(VC_W)) u_arb (
        .req (elig),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (any_gnt)
    );

    assign fifo_rd_en = gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            ptr_q      <= '0;
            vld_q      <= 1'b0;
            vc_q       <= '0;
            cred_err_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            vld_q <= any_gnt;
            if (any_gnt) begin
                vc_q  <= gnt_idx;
                ptr_q <= (gnt_idx == VC_W'(NUM_VC - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (|ovf) cred_err_q <= 1'b1;
        end
    end

    // Grant and return in the same cycle cancel; returns saturate at CREDITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VC; i++) credit_q[i] <= CW'(CREDITS);
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (gnt[i] && !credit_ret[i])
                    credit_q[i] <= credit_q[i] - 1'b1;
                else if (!gnt[i] && credit_ret[i] && credit_q[i] != CW'(CREDITS))
                    credit_q[i] <= credit_q[i] + 1'b1;
            end
        end
    end

    assign link_valid = vld_q;
    assign link_vc    = vc_q;
    assign link_data  = vld_q ? fifo_vec[vc_q] : '0;
    assign cred_err   = cred_err_q;

`ifdef VC_SCHED_STATS_EN
    logic [NUM_VC-1:0][15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_VC; i++)
                if (gnt[i]) cnt_q[i] <= cnt_q[i] + 16'd1;
        end
    end

    assign grant_cnt = cnt_q;
`else
`endif

endmodule

// File: tb/tb_vc_link_scheduler.sv
// Bench for vc_link_scheduler: directed table, corner sequences, random traffic vs model.
module tb_vc_link_scheduler;

    localparam int NV = 4;
    localparam int NB = 32;
    localparam int CR = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sched_en = 1'b0;
    logic [NV-1:0]   fifo_empty = '1;
    logic [NV*NB-1:0] fifo_data = '0;
    logic [NV-1:0]   fifo_rd_en;
    logic [NV-1:0]   credit_ret = '0;
    logic            link_valid;
    logic [1:0]      link_vc;
    logic [NB-1:0]   link_data;
    logic            cred_err;
`ifdef VC_SCHED_STATS_EN
    logic [NV*16-1:0] grant_cnt;
`endif

    vc_link_scheduler #(.NUM_VC(NV), .NUM_BITS(NB), .CREDITS(CR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sched_en   (sched_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .credit_ret (credit_ret),
        .link_valid (link_valid),
        .link_vc    (link_vc),
        .link_data  (link_data),
        .cred_err   (cred_err)
`ifdef VC_SCHED_STATS_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // FIFO contents still to be popped, and each FIFO's registered output.
    logic [NB-1:0] q [NV][$];
    logic [NB-1:0] fdata [NV];

    // Reference model state.
    int            m_cred [NV];
    int            m_cnt  [NV];
    int            m_ptr;
    bit            m_run, m_err, m_vld;
    int            m_vc;
    logic [NB-1:0] m_data;

    // Pre-edge samples of the last cycle.
    logic [NV-1:0] s_rd;
    logic          s_vld, s_err;
    logic [1:0]    s_vc;
    logic [NB-1:0] s_data;

    typedef struct {
        bit          en;
        logic [3:0]  ret;
        logic [3:0]  rd;
        bit          vld;
        logic [1:0]  vc;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_cred[v] = CR;
            m_cnt[v]  = 0;
        end
        m_ptr = 0; m_run = 0; m_err = 0; m_vld = 0; m_vc = 0; m_data = '0;
    endfunction

    function automatic int model_pick(input bit en);
        int v;
        if (!en || !m_run) return -1;
        for (int k = 0; k < NV; k++) begin
            v = (m_ptr + k) % NV;
            if (q[v].size() > 0 && m_cred[v] > 0) return v;
        end
        return -1;
    endfunction

    task automatic drive_fifo();
        for (int v = 0; v < NV; v++) begin
            fifo_empty[v] = (q[v].size() == 0);
            fifo_data[v*NB +: NB] = fdata[v];
        end
    endtask

    task automatic cycle(input bit en, input logic [NV-1:0] ret);
        int            eg;
        logic [NB-1:0] head;
        logic [NV-1:0] exp_rd;
        bit            g;
        sched_en   = en;
        credit_ret = ret;
        drive_fifo();
        #1;
        eg = model_pick(en);
        exp_rd = '0;
        head = '0;
        if (eg >= 0) begin
            exp_rd[eg] = 1'b1;
            head = q[eg][0];
        end
        s_rd = fifo_rd_en; s_vld = link_valid; s_vc = link_vc;
        s_data = link_data; s_err = cred_err;
        chk("rd_en", s_rd, exp_rd);
        chk("link_valid", s_vld, m_vld);
        if (m_vld) begin
            chk("link_vc", s_vc, m_vc);
            chk("link_data", s_data, m_data);
        end else begin
            chk("link_data_idle", s_data, 0);
        end
        chk("cred_err", s_err, m_err);
        @(posedge clk);
        #1;
        for (int v = 0; v < NV; v++)
            if (s_rd[v] && q[v].size() > 0) fdata[v] = q[v].pop_front();
        for (int v = 0; v < NV; v++) begin
            g = (eg == v);
            if (g && !ret[v]) m_cred[v]--;
            else if (!g && ret[v]) begin
                if (m_cred[v] == CR) m_err = 1;
                else m_cred[v]++;
            end
        end
        m_vld = (eg >= 0);
        if (eg >= 0) begin
            m_vc = eg;
            m_data = head;
            m_ptr = (eg + 1) % NV;
            m_cnt[eg] = (m_cnt[eg] + 1) % 65536;
        end
        m_run = rst_n;
        credit_ret = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_link_valid", link_valid, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_link_data", link_data, 0);
        chk("rst_link_vc", link_vc, 0);
        chk("rst_cred_err", cred_err, 0);
`ifdef VC_SCHED_STATS_EN
        chk("rst_grant_cnt", grant_cnt, 0);
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        drive_fifo();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int            prev_g, n;
        logic [NV-1:0] prev_rd, ret;
        logic [3:0]    exp_fair;

        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0};
        tbl[1]  = '{1'b1, 4'b0000, 4'b0100, 1'b0, 2'd0, 32'h0};
        tbl[2]  = '{1'b1, 4'b0000, 4'b0100, 1'b1, 2'd2, 32'h200};
        tbl[3]  = '{1'b1, 4'b0000, 4'b0100, 1'b1, 2'd2, 32'h201};
        tbl[4]  = '{1'b1, 4'b0000, 4'b0100, 1'b1, 2'd2, 32'h202};
        tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 2'd2, 32'h203};
        tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0};
        tbl[7]  = '{1'b1, 4'b0100, 4'b0000, 1'b0, 2'd0, 32'h0};
        tbl[8]  = '{1'b1, 4'b0000, 4'b0100, 1'b0, 2'd0, 32'h0};
        tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 2'd2, 32'h204};
        tbl[10] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0};

        // Reset held with every FIFO claiming data.
        for (int v = 0; v < NV; v++) fdata[v] = '0;
        sched_en = 1'b1;
        fifo_empty = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_en", fifo_rd_en, 0);
        chk("reset_link_valid", link_valid, 0);
        chk("reset_cred_err", cred_err, 0);
        chk("reset_link_vc", link_vc, 0);
        chk("reset_link_data", link_data, 0);
        model_reset();
        for (int i = 0; i < 6; i++) q[2].push_back(32'h200 + i);
        drive_fifo();
        rst_n = 1'b1;

        // Single VC with four credits, then one credit return.
        for (int r = 0; r < 11; r++) begin
            cycle(tbl[r].en, tbl[r].ret);
            chk($sformatf("tbl%0d_rd", r), s_rd, tbl[r].rd);
            chk($sformatf("tbl%0d_vld", r), s_vld, tbl[r].vld);
            if (tbl[r].vld) begin
                chk($sformatf("tbl%0d_vc", r), s_vc, tbl[r].vc);
                chk($sformatf("tbl%0d_data", r), s_data, tbl[r].data);
            end else begin
                chk($sformatf("tbl%0d_data", r), s_data, 0);
            end
        end

        // Fairness with credits echoed back.
        for (int v = 0; v < NV; v++)
            for (int i = 0; i < 8; i++) q[v].push_back(32'h1000 * (v + 1) + i);
        cycle(1'b1, 4'b0100);
        prev_rd = s_rd;
        prev_g = 0;
        for (int v = 0; v < NV; v++) if (s_rd[v]) prev_g = v;
        for (int c = 0; c < 12; c++) begin
            cycle(1'b1, prev_rd);
            exp_fair = 4'b0001 << ((prev_g + 1) % NV);
            chk("fair_order", s_rd, exp_fair);
            chk("fair_valid", s_vld, 1);
            prev_rd = s_rd;
            for (int v = 0; v < NV; v++) if (s_rd[v]) prev_g = v;
        end
        cycle(1'b0, prev_rd);
        chk("en_off_rd", s_rd, 0);
        chk("en_off_inflight", s_vld, 1);

        // Reset with a flit in flight.
        cycle(1'b1, 4'b0000);
        apply_reset();
        cycle(1'b1, 4'b0000);
        chk("post_reset_idle", s_rd, 0);
        cycle(1'b1, 4'b0000);
        chk("post_reset_first", s_rd, 4'b0001);

        // Grant and credit return on the same VC in the same cycle.
        apply_reset();
        for (int v = 0; v < NV; v++) q[v].delete();
        for (int i = 0; i < 6; i++) q[1].push_back(32'h5100 + i);
        cycle(1'b1, 4'b0000);
        repeat (3) cycle(1'b1, 4'b0000);
        cycle(1'b1, 4'b0010);
        chk("simul_a", s_rd, 4'b0010);
        cycle(1'b1, 4'b0000);
        chk("simul_b", s_rd, 4'b0010);
        cycle(1'b1, 4'b0000);
        chk("simul_c", s_rd, 4'b0000);

        // Credit return to a full VC.
        cycle(1'b1, 4'b1000);
        cycle(1'b1, 4'b0000);
        chk("ovf_err", s_err, 1);
        for (int i = 0; i < 5; i++) q[3].push_back(32'h7300 + i);
        n = 0;
        repeat (8) begin
            cycle(1'b1, 4'b0000);
            if (s_rd[3]) n++;
        end
        chk("ovf_credits", n, CR);
        chk("ovf_sticky", s_err, 1);

        // Random traffic against the model.
        for (int c = 0; c < 300; c++) begin
            if (c == 150) apply_reset();
            if ($urandom_range(1, 0) == 1) q[$urandom_range(NV - 1, 0)].push_back($urandom);
            ret = '0;
            for (int v = 0; v < NV; v++)
                if (m_cred[v] < CR && $urandom_range(2, 0) == 0) ret[v] = 1'b1;
            cycle($urandom_range(7, 0) != 0, ret);
        end
`ifdef VC_SCHED_STATS_EN
        for (int v = 0; v < NV; v++)
            chk($sformatf("grant_cnt%0d", v), grant_cnt[v*16 +: 16], m_cnt[v]);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
